// File: rtl/intc_timer_pkg.sv
// Shared definitions for the interrupt controller with interval timer.
// Register indices, CTRL bit positions, request FSM states, helpers.
package intc_timer_pkg;

    localparam logic [2:0] REG_PEND  = 3'd0;
    localparam logic [2:0] REG_MASK  = 3'd1;
    localparam logic [2:0] REG_LOAD  = 3'd2;
    localparam logic [2:0] REG_CTRL  = 3'd3;
    localparam logic [2:0] REG_COUNT = 3'd4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_AUTO = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } req_state_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/intc_timer_interval_timer.sv
// Interval timer: LOAD/CTRL/COUNT registers and a one-cycle expiry tick.
// The tick fires on the edge where count moves from 1 to 0.
module intc_interval_timer
    import intc_timer_pkg::*;
#(
    parameter int TW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          reg_we,
    input  logic [2:0]    reg_addr,
    input  logic [31:0]   reg_wdata,
    output logic [TW-1:0] load,
    output logic [1:0]    ctrl,
    output logic [TW-1:0] count,
    output logic          tick
);

    localparam logic [TW-1:0] ONE = 1;

    logic [TW-1:0] load_q, load_d;
    logic [TW-1:0] count_q, count_d;
    logic          en_q, en_d;
    logic          auto_q, auto_d;
    logic          wr_load;
    logic          wr_ctrl;
    logic          stop;
    logic          run;
    logic [31:0]   unused_wdata;

    assign unused_wdata = reg_wdata;

    assign wr_load = reg_we && (reg_addr == REG_LOAD);
    assign wr_ctrl = reg_we && (reg_addr == REG_CTRL);
    assign stop    = wr_ctrl && !reg_wdata[CTRL_EN];
    assign run     = en_q && !stop;

    // Countdown, expiry, reload and register writes.
    always_comb begin
        load_d  = load_q;
        count_d = count_q;
        en_d    = en_q;
        auto_d  = auto_q;
        tick    = 1'b0;
        if (run) begin
            if (count_q == ONE) begin
                tick    = 1'b1;
                count_d = '0;
                if (!auto_q) begin
                    en_d = 1'b0;
                end
            end else if (count_q != '0) begin
                count_d = count_q - ONE;
            end else if (auto_q) begin
                count_d = load_q;
            end
        end
        if (wr_load) begin
            load_d = reg_wdata[TW-1:0];
        end
        if (wr_ctrl) begin
            en_d   = reg_wdata[CTRL_EN];
            auto_d = reg_wdata[CTRL_AUTO];
            if (reg_wdata[CTRL_EN] && !en_q) begin
                count_d = load_q;
            end
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
        end else begin
            load_q  <= load_d;
            count_q <= count_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
        end
    end

    assign load  = load_q;
    assign count = count_q;
    assign ctrl  = {auto_q, en_q};

endmodule

// File: rtl/intc_timer.sv
// Interrupt controller feeding CP0, with optional interval timer on source 0.
// Timer compiled in only when INTC_TIMER_EN is defined.
module intc_timer
    import intc_timer_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int TW   = 32
) (
    input  logic            clk_o,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            reg_we,
    input  logic [2:0]      reg_addr,
    input  logic [31:0]     reg_wdata,
    output logic [31:0]     reg_rdata,
    output logic            intr,
    output logic [3:0]      irq_id,
    input  logic            inta
);

    localparam logic [NSRC-1:0] ONE = 1;

    logic [NSRC-1:0] s1_q, s1_d;
    logic [NSRC-1:0] s2_q, s2_d;
    logic [NSRC-1:0] prev_q, prev_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] edge_w;
    logic [NSRC-1:0] set_w;
    logic [NSRC-1:0] w1c_w;
    logic [NSRC-1:0] ack_w;
    logic [NSRC-1:0] active;
    logic            tick;
    logic [31:0]     unused_wdata;

    req_state_e      state_q;
    logic            intr_q;
    logic [3:0]      irq_id_q;

    assign unused_wdata = reg_wdata;

`ifdef INTC_TIMER_EN
    logic [TW-1:0]   t_load;
    logic [1:0]      t_ctrl;
    logic [TW-1:0]   t_count;

    intc_interval_timer #(
        .TW (TW)
    ) u_timer (
        .clk       (clk_o),
        .rst_n     (rst),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .load      (t_load),
        .ctrl      (t_ctrl),
        .count     (t_count),
        .tick      (tick)
    );
`else
    logic [TW-1:0]   unused_tw;

    assign unused_tw = '0;
    assign tick      = 1'b0;
`endif

    // Two-flop synchroniser plus previous-value flop for edge detect.
    always_comb begin
        s1_d   = irq_src;
        s2_d   = s1_q;
        prev_d = s2_q;
        edge_w = s2_q & ~prev_q;
    end

    // Pending set sources: external edges, timer owns bit 0 when present.
    always_comb begin
        set_w = edge_w;
`ifdef INTC_TIMER_EN
        set_w[0] = tick;
`else
        set_w[0] = edge_w[0] | tick;
`endif
    end

    // Pending clears (W1C and acknowledge) lose to a same-cycle set.
    always_comb begin
        w1c_w = '0;
        ack_w = '0;
        if (reg_we && (reg_addr == REG_PEND)) begin
            w1c_w = reg_wdata[NSRC-1:0];
        end
        if ((state_q == ST_REQ) && inta) begin
            ack_w = ONE << irq_id_q;
        end
        pend_d = (pend_q & ~(w1c_w | ack_w)) | set_w;
    end

    // Mask register write.
    always_comb begin
        mask_d = mask_q;
        if (reg_we && (reg_addr == REG_MASK)) begin
            mask_d = reg_wdata[NSRC-1:0];
        end
    end

    assign active = pend_q & mask_q;

    // Edge detect, pending and mask registers.
    always_ff @(posedge clk_o or negedge rst) begin
        if (!rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
        end
    end

    // Request FSM with registered intr/irq_id towards CP0.
    always_ff @(posedge clk_o or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            intr_q   <= 1'b0;
            irq_id_q <= 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (active != '0) begin
                        state_q  <= ST_REQ;
                        intr_q   <= 1'b1;
                        irq_id_q <= lowest_idx(16'(active));
                    end
                end
                ST_REQ: begin
                    if (inta) begin
                        state_q <= ST_WAIT;
                        intr_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    state_q <= ST_IDLE;
                    intr_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign intr   = intr_q;
    assign irq_id = irq_id_q;

    // Combinational register read port.
    always_comb begin
        reg_rdata = 32'd0;
        case (reg_addr)
            REG_PEND:  reg_rdata = 32'(pend_q);
            REG_MASK:  reg_rdata = 32'(mask_q);
`ifdef INTC_TIMER_EN
            REG_LOAD:  reg_rdata = 32'(t_load);
            REG_CTRL:  reg_rdata = 32'(t_ctrl);
            REG_COUNT: reg_rdata = 32'(t_count);
`endif
            default:   reg_rdata = 32'd0;
        endcase
    end

endmodule

// File: doc/intc_timer.md
Name: intc_timer

Overview:
- Interrupt controller with an integrated interval timer.
- Sits directly upstream of cpu_with_cp0 and drives its external interrupt request line.
- CP0 returns an acknowledge when it takes the exception.
- The CPU data-memory stage programs the block through a small word-addressed register port: mask, pending, timer load/control/count.

Parameters:
- NSRC, 8, number of interrupt sources; bit 0 is the timer when the timer is compiled in (2..16).
- TW, 32, timer counter width.

Ports:
- clk_o  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq_src  in  NSRC  raw asynchronous interrupt lines, rising-edge triggered.
- reg_we  in  1  register write strobe, one cycle.
- reg_addr  in  3  word index: 0 PEND, 1 MASK, 2 LOAD, 3 CTRL, 4 COUNT.
- reg_wdata  in  32  write data.
- reg_rdata  out  32  read data, combinational from reg_addr.
- intr  out  1  interrupt request to CP0, registered.
- irq_id  out  4  index of the granted source, valid while intr=1.
- inta  in  1  one-cycle acknowledge from CP0 on exception entry.

Behaviour:
- Reset (rst=0, asynchronous): all registers clear.
  - pend, mask, load, ctrl, count, sync/edge flops = 0.
  - intr=0, irq_id=0, FSM=IDLE.
- Input synchronisation: irq_src passes through two flops (s1, s2) and a previous-value flop; edge = s2 & ~prev.
- Pending:
  - An edge sets pend[i].
  - Writing PEND with bit i=1 clears pend[i] (write-1-to-clear).
  - If a set and a clear of the same bit occur in the same cycle, set wins.
  - reg_rdata for PEND returns pend, zero-extended.
- MASK: read/write, low NSRC bits; bit=1 enables the source.
- Request FSM, which reads active = pend & mask:
  - IDLE: if active != 0, go to REQ; latch irq_id = lowest set index of active; intr=1 from the next cycle.
  - REQ: intr held at 1 and irq_id stable until inta=1. On inta, clear pend[irq_id] (set wins if a new edge arrives that cycle) and go to WAIT; intr=0 in WAIT.
  - WAIT: one dead cycle so CP0 sees intr deassert; then back to IDLE.
  - Masking a source while in REQ does not withdraw intr.
  - inta outside REQ is ignored.
- Latency: irq_src rising at clock edge k (first sampled high) gives:
  - edge detected at k+2;
  - pend set at k+2;
  - intr=1 after edge k+3.
- Timer:
  - CTRL bit0 = EN, bit1 = AUTO; LOAD and COUNT are TW bits wide.
  - A write that sets EN from 0 to 1 loads count=load in that cycle.
  - While EN=1 and count != 0, count decrements each cycle.
  - On the transition count 1->0, set pend[0]. Then:
    - AUTO=1: count reloads with load on the next cycle.
    - AUTO=0: EN clears.
  - load=0 with EN=1: no decrement, no interrupt.
  - Writing LOAD while running takes effect only at the next reload or enable.
  - Writing EN=0 freezes count.
  - COUNT is read-only; writes are ignored.
- Unused addresses read 0; writes to them are ignored.

Optional Feature:
- Macro: INTC_TIMER_EN.
- Defined: the timer exists as above; pend[0] is driven by the timer and irq_src[0] is ignored.
- Undefined: no timer logic; LOAD, CTRL and COUNT read 0 and ignore writes; source 0 is an ordinary external line from irq_src[0].

Decomposition:
- Shared package: register index constants (PEND=0, MASK=1, LOAD=2, CTRL=3, COUNT=4), CTRL bit positions, FSM state encoding (IDLE, REQ, WAIT).
- One natural sub-module, intc_interval_timer, holding load/ctrl/count and producing a one-cycle tick; instantiated only under INTC_TIMER_EN.

Test Plan:
- Reset then idle: assert rst=0 mid-operation with intr=1 -> intr=0, pend=0, count=0 immediately and asynchronously; all reads return 0 after release.
- Single source: mask=0x04, irq_src[2] rises at edge k -> intr=1 after edge k+3 with irq_id=2; inta pulse -> intr=0 next cycle, PEND reads 0x00, intr stays 0.
- Priority and masking: mask=0x0C, sources 2 and 3 rise together -> irq_id=2. After inta, and the WAIT cycle, intr reasserts with irq_id=3. Source 5 rising (unmasked bit off) sets pend bit 5 but never intr.
- W1C versus set collision: write PEND=0x02 in the same cycle an edge on source 1 is detected -> pend[1] remains 1.
- Timer auto-reload (INTC_TIMER_EN): load=3, CTRL=0x3, mask=0x01 -> pend[0] sets every 4 cycles after enable; intr/irq_id=0; COUNT sequence reads 3,2,1,0,3,...
- Timer one-shot and zero load: load=5, CTRL=0x1 -> single interrupt, then CTRL reads 0x0. load=0, CTRL=0x1 -> no interrupt, COUNT stays 0. Without the macro, LOAD/CTRL/COUNT read 0.
